rr_grant_encoder: RTL and testbench

Round-robin arbiter for 16 requesters that emits the winning requester as a registered 4-bit binary index with a valid/ready handshake. It sits directly upstream of the 4-to-16 binary decoder: the decoder turns `grant_idx` back into a one-hot grant vector for the requesters. Fairness is by a rotating priority pointer that advances past each accepted winner.

---
 rtl/rr_arb_pkg.sv | 23 ++
 rtl/rr_pick.sv | 36 +++
 rtl/rr_grant_encoder.sv | 97 +++++++++
 tb/tb_rr_grant_encoder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// -----------------------------------------------------------------------------
// rr_arb_pkg
// Shared widths, types and FSM encoding for the round-robin grant encoder.
//   N_REQ   : number of requesters (16)
//   IDX_W   : width of a requester index (4)
//   req_t   : request vector, bit i = requester i
//   idx_t   : binary requester index
//   state_t : arbiter FSM states {IDLE, OFFER}
// -----------------------------------------------------------------------------
package rr_arb_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;

    typedef logic [N_REQ-1:0] req_t;
    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotated-priority search: returns the first set bit of req
// visiting start, start+1, ... modulo N_REQ.
//   req   : in  request vector
//   start : in  index with highest priority
//   found : out at least one request is set
//   idx   : out index of the winner (equals start when found = 0)
// -----------------------------------------------------------------------------
module rr_pick
    import rr_arb_pkg::*;
(
    input  req_t req,
    input  idx_t start,
    output logic found,
    output idx_t idx
);

    idx_t w_cand;

    // Scan from the farthest offset down to offset 0 so the nearest set bit
    // after start is the last one written and therefore wins.
    always_comb begin
        found  = 1'b0;
        idx    = start;
        w_cand = start;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_cand = start + idx_t'(i);
            if (req[w_cand]) begin
                found = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/rr_grant_encoder.sv
// -----------------------------------------------------------------------------
// rr_grant_encoder
// Round-robin arbiter for 16 requesters. The winner is offered as a
// registered binary index under a valid/ready handshake; the offer is held
// stable until accepted regardless of later request changes.
//   clk         : in  rising-edge clock
//   rst         : in  asynchronous active-high reset
//   req         : in  request lines, bit i = requester i
//   grant_ready : in  consumer accepts the offered grant this cycle
//   grant_valid : out grant offered (registered)
//   grant_idx   : out index of the granted requester (registered)
//   lock        : in  keep the current winner on accept (RR_ARB_LOCK_EN only)
// Configuration macro: RR_ARB_LOCK_EN adds the lock port and hold-on-accept.
// -----------------------------------------------------------------------------
module rr_grant_encoder
    import rr_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             grant_ready,
`ifdef RR_ARB_LOCK_EN
    input  logic             lock,
`endif
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    state_t r_state;
    idx_t   r_ptr;
    logic   r_grant_valid;
    idx_t   r_grant_idx;

    idx_t   w_idx_inc;
    idx_t   w_start;
    logic   w_found;
    idx_t   w_pick_idx;
    logic   w_hold;

    // Accepted requester drops to lowest priority: next search starts after it.
    assign w_idx_inc = r_grant_idx + idx_t'(1);
    assign w_start   = (r_state == OFFER) ? w_idx_inc : r_ptr;

`ifdef RR_ARB_LOCK_EN
    // Lock only matters while the locked requester is still asking.
    assign w_hold = lock && req[r_grant_idx];
`else
    assign w_hold = 1'b0;
`endif

    rr_pick u_pick (
        .req   (req),
        .start (w_start),
        .found (w_found),
        .idx   (w_pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_grant_valid <= 1'b0;
            r_grant_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant_idx   <= w_pick_idx;
                        r_grant_valid <= 1'b1;
                        r_state       <= OFFER;
                    end
                end
                OFFER: begin
                    // Offer is frozen until accepted; a held lock re-offers
                    // the same index without moving the pointer.
                    if (grant_ready && !w_hold) begin
                        r_ptr <= w_idx_inc;
                        if (w_found) begin
                            r_grant_idx <= w_pick_idx;
                        end else begin
                            r_grant_valid <= 1'b0;
                            r_state       <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_grant_valid <= 1'b0;
                end
            endcase
        end
    end

    assign grant_valid = r_grant_valid;
    assign grant_idx   = r_grant_idx;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// -----------------------------------------------------------------------------
// tb_rr_grant_encoder
// Directed-vector bench for rr_grant_encoder. Inputs change on the falling
// edge; outputs are sampled on the falling edge, half a cycle after the
// rising edge that produced them.
// -----------------------------------------------------------------------------
module tb_rr_grant_encoder;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic        grant_ready;
    logic        grant_valid;
    logic [3:0]  grant_idx;
`ifdef RR_ARB_LOCK_EN
    logic        lock;
`endif

    int n_vec;
    int n_err;

    rr_grant_encoder dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant_ready (grant_ready),
`ifdef RR_ARB_LOCK_EN
        .lock        (lock),
`endif
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Check one offered grant at the current falling edge.
    task automatic chk_offer(input string tag, input logic [3:0] exp_idx);
        chk({tag, "_vld"}, {31'd0, grant_valid}, 32'd1);
        chk({tag, "_idx"}, {28'd0, grant_idx}, {28'd0, exp_idx});
    endtask

    initial begin
        logic [3:0] seq2 [4];
        logic [3:0] seq3 [3];
        n_vec = 0;
        n_err = 0;
        seq2 = '{4'd0, 4'd15, 4'd0, 4'd15};
        seq3 = '{4'd0, 4'd1, 4'd14};
        rst = 1'b1;
        req = '0;
        grant_ready = 1'b0;
`ifdef RR_ARB_LOCK_EN
        lock = 1'b0;
`endif

        // Reset state
        #2;
        chk("rst_vld", {31'd0, grant_valid}, 32'd0);
        chk("rst_idx", {28'd0, grant_idx}, 32'd0);

        // 1: offer idx 4, then async reset mid-offer
        @(negedge clk);
        rst = 1'b0;
        req = 16'h0010;
        @(negedge clk);
        chk_offer("t1_offer", 4'd4);
        #2 rst = 1'b1;
        #1;
        chk("t1_async_vld", {31'd0, grant_valid}, 32'd0);
        chk("t1_async_idx", {28'd0, grant_idx}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req = 16'h0001;
        @(negedge clk);
        chk_offer("t1_post", 4'd0);

        // 2: two requesters alternate, one accept per cycle
        req = 16'h8001;
        grant_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk_offer("t2_alt", seq2[k]);
            if (k == 3) req = 16'h4000;
            @(negedge clk);
        end

        // 3: wrap through 15 -> 0 after accepting 14
        chk_offer("t3_pre", 4'd14);
        req = 16'h4003;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk_offer("t3_wrap", seq3[k]);
            if (k == 2) req = 16'h0000;
            @(negedge clk);
        end
        chk("t3_idle_vld", {31'd0, grant_valid}, 32'd0);

        // 4: backpressure, offer stays stable even after req drops
        grant_ready = 1'b0;
        req = 16'h0010;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            chk_offer("t4_hold", 4'd4);
            if (c == 2) req = 16'h0000;
            @(negedge clk);
        end
        chk_offer("t4_last", 4'd4);
        grant_ready = 1'b1;
        @(negedge clk);
        chk("t4_done_vld", {31'd0, grant_valid}, 32'd0);

        // 5: all requesting from reset, full rotation with no gaps
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 16'hFFFF;
        grant_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 17; k++) begin
            chk_offer("t5_rot", 4'(k));
            @(negedge clk);
        end

`ifdef RR_ARB_LOCK_EN
        // 6: lock holds winner, release resumes rotation
        rst = 1'b1;
        req = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
        req = 16'h0006;
        grant_ready = 1'b1;
        lock = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk_offer("t6_lock", 4'd1);
            @(negedge clk);
        end
        lock = 1'b0;
        chk_offer("t6_rel0", 4'd1);
        @(negedge clk);
        chk_offer("t6_rel1", 4'd2);
        @(negedge clk);
        chk_offer("t6_rel2", 4'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
